// File: rtl/alu_chk_pkg.sv
// Shared types and default command constants for the ALU bus protocol checker.
package alu_chk_pkg;

  localparam int NUM_CHK = 5;

  typedef enum logic [2:0] {
    CHK_TIMEOUT   = 3'd0,
    CHK_BAD_CMD   = 3'd1,
    CHK_NO_VALID  = 3'd2,
    CHK_ROT_RANGE = 3'd3,
    CHK_CE_HOLD   = 3'd4
  } chk_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int DEF_ARITH_MAX = 10;
  localparam int DEF_LOGIC_MAX = 13;
  localparam int DEF_ROR_CMD   = 12;
  localparam int DEF_ROL_CMD   = 13;

endpackage

// File: rtl/alu_chk_err_window.sv
// Tracks an error trigger for ERR_WINDOW cycles and flags it if ERR never answered.
module alu_chk_err_window #(
  parameter int ERR_WINDOW = 5
) (
  input  logic CLK,
  input  logic RESET,
  input  logic trig,
  input  logic err,
  output logic viol
);

  logic [ERR_WINDOW-1:0] p;
  logic [ERR_WINDOW-1:0] p_next;

  // ERR acknowledges every older trigger; a trigger in the same cycle still starts a window.
  generate
    if (ERR_WINDOW == 1) begin : g_one
      assign p_next = trig;
    end else begin : g_shift
      assign p_next = err ? {{(ERR_WINDOW-1){1'b0}}, trig} : {p[ERR_WINDOW-2:0], trig};
    end
  endgenerate

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) p <= '0;
    else       p <= p_next;
  end

  assign viol = p[ERR_WINDOW-1] & ~err;

endmodule

// File: rtl/alu_protocol_checker.sv
// Protocol checker for the ALU bus: operand timeout, command legality, error windows
// and clock-enable hold, each reported as pulse, sticky bit and saturating counter.
module alu_protocol_checker
  import alu_chk_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int RES_WIDTH  = WIDTH + 1,
  parameter int TIMEOUT    = 16,
  parameter int ERR_WINDOW = 5,
  parameter int CNT_W      = 16,
  parameter int ARITH_MAX  = DEF_ARITH_MAX,
  parameter int LOGIC_MAX  = DEF_LOGIC_MAX,
  parameter int ROR_CMD    = DEF_ROR_CMD,
  parameter int ROL_CMD    = DEF_ROL_CMD
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CE,
  input  logic                 MODE,
  input  logic                 CIN,
  input  logic [CMD_WIDTH-1:0] CMD,
  input  logic [1:0]           INP_VALID,
  input  logic [WIDTH-1:0]     OPA,
  input  logic [WIDTH-1:0]     OPB,
  input  logic [RES_WIDTH-1:0] RES,
  input  logic                 ERR,
  input  logic                 COUT,
  input  logic                 OFLOW,
  input  logic                 G,
  input  logic                 L,
  input  logic                 E,
  input  logic [NUM_CHK-1:0]   chk_en,
  input  logic                 clr,
  input  logic [2:0]           cnt_sel,
  output logic [CNT_W-1:0]     cnt_rdata,
  output logic [NUM_CHK-1:0]   viol_pulse,
  output logic [NUM_CHK-1:0]   viol_sticky,
  output logic                 wait_busy
);

  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int ROT_SH = $clog2(WIDTH) + 1;
  localparam int HW     = RES_WIDTH + 6;
  localparam logic [CMD_WIDTH-1:0] ARITH_MAX_C = CMD_WIDTH'(ARITH_MAX);
  localparam logic [CMD_WIDTH-1:0] LOGIC_MAX_C = CMD_WIDTH'(LOGIC_MAX);
  localparam logic [CMD_WIDTH-1:0] ROR_C       = CMD_WIDTH'(ROR_CMD);
  localparam logic [CMD_WIDTH-1:0] ROL_C       = CMD_WIDTH'(ROL_CMD);
  localparam logic [TW-1:0]        TIMEOUT_C   = TW'(TIMEOUT);

  state_e             state;
  logic [TW-1:0]      to_cnt;
  logic [1:0]         part;
  logic               cmd_legal, partial, complete;
  logic               trig_bad, trig_nov, trig_rot;
  logic               win_bad, win_nov, win_rot;
  logic [HW-1:0]      hist, cur;
  logic               hold_armed;
  logic [NUM_CHK-1:0] viol;
  logic [CNT_W-1:0]   cnt [NUM_CHK];
  logic               unused_inputs;

  assign unused_inputs = ^{CIN, OPA};

  assign cmd_legal = MODE ? (CMD <= ARITH_MAX_C) : (CMD <= LOGIC_MAX_C);
  assign partial   = (INP_VALID == 2'b01) || (INP_VALID == 2'b10);
  assign complete  = CE && ((INP_VALID == 2'b11) || (INP_VALID == ~part));

  assign trig_bad = chk_en[CHK_BAD_CMD] & CE & ~cmd_legal;
  assign trig_nov = chk_en[CHK_NO_VALID] & CE & (INP_VALID == 2'b00);
  assign trig_rot = chk_en[CHK_ROT_RANGE] & CE & ~MODE & ((CMD == ROR_C) || (CMD == ROL_C))
                  & ((OPB >> ROT_SH) != '0);

  alu_chk_err_window #(.ERR_WINDOW(ERR_WINDOW)) u_win_bad (
    .CLK(CLK), .RESET(RESET), .trig(trig_bad), .err(ERR), .viol(win_bad)
  );
  alu_chk_err_window #(.ERR_WINDOW(ERR_WINDOW)) u_win_nov (
    .CLK(CLK), .RESET(RESET), .trig(trig_nov), .err(ERR), .viol(win_nov)
  );
  alu_chk_err_window #(.ERR_WINDOW(ERR_WINDOW)) u_win_rot (
    .CLK(CLK), .RESET(RESET), .trig(trig_rot), .err(ERR), .viol(win_rot)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
      part   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (chk_en[CHK_TIMEOUT] && CE && cmd_legal && partial) begin
            state  <= ST_WAIT;
            part   <= INP_VALID;
            to_cnt <= TW'(1);
          end
        end
        ST_WAIT: begin
          if (complete || to_cnt == TIMEOUT_C) state <= ST_IDLE;
          else                                 to_cnt <= to_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wait_busy = (state == ST_WAIT);

  // Output/flag snapshot; hold_armed means CE was low at the previous sample.
  assign cur = {RES, COUT, OFLOW, G, L, E, ERR};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hist       <= '0;
      hold_armed <= 1'b0;
    end else begin
      hist       <= cur;
      hold_armed <= ~CE;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    viol                = '0;
    viol[CHK_TIMEOUT]   = chk_en[CHK_TIMEOUT] && (state == ST_WAIT) && !complete
                          && (to_cnt == TIMEOUT_C) && !ERR;
    viol[CHK_BAD_CMD]   = chk_en[CHK_BAD_CMD] & win_bad;
    viol[CHK_NO_VALID]  = chk_en[CHK_NO_VALID] & win_nov;
    viol[CHK_ROT_RANGE] = chk_en[CHK_ROT_RANGE] & win_rot;
    viol[CHK_CE_HOLD]   = chk_en[CHK_CE_HOLD] & hold_armed & (cur != hist);
  end

  // NOTE: the counter array is reset because it is architecturally visible, unlike RAM contents.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      viol_pulse  <= '0;
      viol_sticky <= '0;
      for (int i = 0; i < NUM_CHK; i++) cnt[i] <= '0;
    end else begin
      viol_pulse  <= viol;
      viol_sticky <= (clr ? '0 : viol_sticky) | viol;
      for (int i = 0; i < NUM_CHK; i++) begin
        if (viol[i])  cnt[i] <= clr ? CNT_W'(1) : ((cnt[i] == '1) ? cnt[i] : cnt[i] + 1'b1);
        else if (clr) cnt[i] <= '0;
      end
    end
  end

  always_comb begin
    cnt_rdata = '0;
    if (cnt_sel < 3'(NUM_CHK)) cnt_rdata = cnt[cnt_sel];
  end

endmodule

// File: doc/alu_protocol_checker.md
# alu_protocol_checker

Synthesizable, parametrised protocol checker for the ALU bus. It observes every ALU input and output at CLK, tracks multi-cycle obligations (the operand-wait timeout, error-flag windows, clock-enable hold), and reports each violation as a one-cycle pulse, a sticky bit and a saturating per-check counter. It is instantiated beside the ALU in the DUT wrapper, so the same checks run in simulation, emulation and silicon debug.

## Interface
- WIDTH, 8, operand width
- CMD_WIDTH, 4, command width
- RES_WIDTH, WIDTH+1, result width
- TIMEOUT, 16, cycles allowed for the second operand to arrive
- ERR_WINDOW, 5, cycles allowed for ERR after an error trigger (≥1)
- CNT_W, 16, violation counter width
- ARITH_MAX, 10, highest legal command when MODE=1
- LOGIC_MAX, 13, highest legal command when MODE=0
- ROR_CMD / ROL_CMD, 12 / 13, rotate commands (MODE=0)
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- CE, MODE, CIN  in  1 each  ALU controls
- CMD  in  CMD_WIDTH  ALU command
- INP_VALID  in  2  operand valid; bit0 = OPA, bit1 = OPB
- OPA, OPB  in  WIDTH  operands
- RES  in  RES_WIDTH  ALU result
- ERR, COUT, OFLOW, G, L, E  in  1 each  ALU flags
- chk_en  in  5  per-check enable
- clr  in  1  synchronous clear of counters and sticky bits
- cnt_sel  in  3  counter select (0-4; values 5-7 read 0)
- cnt_rdata  out  CNT_W  selected counter, combinational from cnt_sel
- viol_pulse  out  5  one-cycle violation pulse, indexed by check
- viol_sticky  out  5  sticky violation bits
- wait_busy  out  1  timeout FSM is in WAIT

## Operation
- Checks: 0 TIMEOUT, 1 BAD_CMD, 2 NO_VALID, 3 ROT_RANGE, 4 CE_HOLD. A check whose chk_en bit is 0 never triggers and never pulses.
- TIMEOUT FSM, states IDLE and WAIT:
  - IDLE→WAIT when CE=1, the command is legal and INP_VALID is 01 or 10. The partial value is latched and the cycle counter loads 1.
  - In WAIT, the operation completes and the FSM returns to IDLE when CE=1 and INP_VALID is either 11 or the complement of the latched value.
  - A repeat of the same partial value, or CE=0, does not complete the operation. The counter still increments every cycle.
  - At count == TIMEOUT: ERR=1 means no violation, ERR=0 means violation. The FSM returns to IDLE either way.
  - A new partial value is not re-armed while the FSM is in WAIT.
- BAD_CMD trigger: CE=1 and ((MODE=1 and CMD>ARITH_MAX) or (MODE=0 and CMD>LOGIC_MAX)).
- NO_VALID trigger: CE=1 and INP_VALID=00.
- ROT_RANGE trigger: CE=1, MODE=0, CMD is ROR_CMD or ROL_CMD, and OPB[WIDTH-1:$clog2(WIDTH)+1] is nonzero.
- Error windows (checks 1-3, each with its own pending vector p[ERR_WINDOW-1:0]):
  - Each cycle, p shifts up with the trigger entering bit 0.
  - ERR=1 clears all older pending bits. A trigger in the same cycle is still recorded.
  - Violation when p[ERR_WINDOW-1]=1 and ERR=0.
- CE_HOLD: if CE=0 at sample n and no reset, then {RES,COUT,OFLOW,G,L,E,ERR} at sample n+1 must equal the values at sample n. This check is skipped for the first sample after reset.
- Counters saturate at 2^CNT_W-1 and increment on the same edge as the pulse.
- On clr: counters and sticky bits clear. A violation in the same cycle as clr wins, leaving the counter at 1 and the sticky bit at 1. FSM and pending vectors are not affected by clr.

## Timing
- All inputs are sampled at posedge CLK. viol_pulse is registered and is high for the one cycle after the failing sample.
- TIMEOUT: trigger at edge t, no completion → ERR checked at edge t+TIMEOUT, pulse in the cycle after it.
- Error windows: trigger at edge t, no ERR at t+1…t+ERR_WINDOW → pulse after edge t+ERR_WINDOW.
- Completion at edge t+k, k≤TIMEOUT: wait_busy is low after edge t+k.
- RESET (async): FSM→IDLE, counter, pending vectors, CE_HOLD history valid flag, pulses, sticky bits and counters all go to 0. wait_busy=0 and cnt_rdata=0.

## Structure
- Package alu_chk_pkg holds:
  - check-index enum: CHK_TIMEOUT…CHK_CE_HOLD, NUM_CHK=5
  - FSM state enum
  - default command constants
- Sub-module alu_chk_err_window holds the pending vector and violation logic (parameter ERR_WINDOW; ports trig, err, viol). It is instantiated three times.

## Test plan
All scenarios use WIDTH=8, TIMEOUT=16, ERR_WINDOW=5.
- CE=1, MODE=1, CMD=0, INP_VALID=01 at edge 0; INP_VALID=10 at edge 5 → wait_busy low after edge 5, no pulse.
- Same as above but no completion:
  - ERR=0 at edge 16 → viol_pulse[0] for one cycle, viol_sticky[0]=1, cnt_sel=0 reads 1.
  - ERR=1 at edge 16 instead → nothing.
- MODE=1, CMD=11 at edge 0:
  - ERR=1 at edge 3 → no pulse.
  - ERR held at 0 → viol_pulse[1] after edge 5.
- MODE=0, CMD=12:
  - OPB=8'h10, ERR held at 0 → viol_pulse[3] after edge 5.
  - OPB=8'h07 → no trigger.
- CE=0 at edge n with RES=9'h012; RES=9'h013 at edge n+1 → viol_pulse[4].
- CNT_W=2 with four INP_VALID=00 violations → counter reads 3. clr → reads 0. RESET asserted mid-WAIT → wait_busy=0 and no TIMEOUT pulse.
